// File: rtl/px_pkg.sv
// Image geometry and pixel word layout shared by the frame-buffer read path
// and the column-histogram logic.
package px_pkg;

  localparam int unsigned c_img_cols    = 80;
  localparam int unsigned c_img_rows    = 60;
  localparam int unsigned c_img_pxls    = c_img_cols * c_img_rows;
  localparam int unsigned c_nb_img_pxls = 13;
  localparam int unsigned c_nb_cols     = 7;
  localparam int unsigned c_nb_rows     = 6;
  localparam int unsigned c_nb_buf      = 12;

  // 4R/4G/4B pixel, red in the MSBs
  localparam int unsigned c_red_msb = 11;
  localparam int unsigned c_grn_msb = 7;
  localparam int unsigned c_blu_msb = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [c_nb_img_pxls-1:0] addr;
    logic [c_nb_cols-1:0]     col;
    logic [c_nb_rows-1:0]     row;
    logic                     eol;
    logic                     eof;
  } px_tag_t;

  typedef struct packed {
    logic [c_nb_buf-1:0] pxl;
    px_tag_t             tag;
  } px_word_t;

endpackage

// File: rtl/px_frame_reader_if.sv
// Frame-buffer read port plus the processed-pixel stream, seen from the reader
// (master) and from the buffer/consumer side (slave).
interface px_frame_reader_if;
  import px_pkg::*;

  logic                     buf_rd_en;
  logic [c_nb_img_pxls-1:0] buf_addr;
  logic [c_nb_buf-1:0]      buf_data;

  logic                     proc_valid;
  logic                     proc_ready;
  logic [c_nb_buf-1:0]      proc_pxl;
  logic [c_nb_img_pxls-1:0] proc_addr;
  logic [c_nb_cols-1:0]     proc_col;
  logic [c_nb_rows-1:0]     proc_row;
  logic                     proc_eol;
  logic                     proc_eof;

  modport master (
    output buf_rd_en, buf_addr,
    input  buf_data,
    output proc_valid, proc_pxl, proc_addr, proc_col, proc_row, proc_eol, proc_eof,
    input  proc_ready
  );

  modport slave (
    input  buf_rd_en, buf_addr,
    output buf_data,
    input  proc_valid, proc_pxl, proc_addr, proc_col, proc_row, proc_eol, proc_eof,
    output proc_ready
  );

endinterface

// File: rtl/px_fifo2.sv
// Two-entry synchronous FIFO; pushing while full is only accepted alongside a pop.
module px_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/px_frame_reader.sv
// Replays one stored 80x60 frame as a raster-ordered, back-pressured pixel
// stream tagged with address, column, row, end-of-line and end-of-frame.
module px_frame_reader
  import px_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_rdy,
  output logic               busy,
  output logic               overrun,
  px_frame_reader_if.master  bus
);

  localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_pxls - 1);
  localparam logic [c_nb_cols-1:0]     c_last_col  = c_nb_cols'(c_img_cols - 1);
  localparam logic [c_nb_rows-1:0]     c_last_row  = c_nb_rows'(c_img_rows - 1);

  rd_state_t                state;
  rd_state_t                state_nxt;
  logic                     rd_go;
  logic                     rd_en;
  logic                     last_rd;
  logic                     inflight;
  logic                     pop;
  logic [2:0]               occupancy;
  logic [c_nb_img_pxls-1:0] rd_addr;
  logic [c_nb_cols-1:0]     rd_col;
  logic [c_nb_rows-1:0]     rd_row;
  px_tag_t                  tag_q;
  px_word_t                 fifo_din;
  px_word_t                 fifo_dout;
  logic [1:0]               fifo_count;
  logic                     fifo_empty;
  logic                     fifo_full;

  // Credit check: FIFO entries plus the read in flight, minus this cycle's pop.
  assign pop       = !fifo_empty && bus.proc_ready;
  assign occupancy = {1'b0, fifo_count} + 3'(inflight) - 3'(pop);
  assign rd_en     = (state == READ) && rd_go && (occupancy < 3'd2)
                     && !(fifo_full && !pop);
  assign last_rd   = (rd_addr == c_last_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_rdy) state_nxt = READ;
      READ:    if (rd_en && last_rd) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !inflight) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reads start one cycle after entry so the final capture write has landed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      overrun <= 1'b0;
      rd_go   <= 1'b0;
    end else begin
      busy  <= (state_nxt != IDLE);
      rd_go <= (state == READ);
      if (frame_rdy && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  // Address and raster position of the next read; address holds at the last pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr <= '0;
      rd_col  <= '0;
      rd_row  <= '0;
    end else if ((state == IDLE) && frame_rdy) begin
      rd_addr <= '0;
      rd_col  <= '0;
      rd_row  <= '0;
    end else if (rd_en && !last_rd) begin
      rd_addr <= rd_addr + c_nb_img_pxls'(1);
      if (rd_col == c_last_col) begin
        rd_col <= '0;
        if (rd_row != c_last_row) begin
          rd_row <= rd_row + c_nb_rows'(1);
        end
      end else begin
        rd_col <= rd_col + c_nb_cols'(1);
      end
    end
  end

  // Tags travel alongside the read so they meet buf_data one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        tag_q <= '{addr: rd_addr,
                   col:  rd_col,
                   row:  rd_row,
                   eol:  (rd_col == c_last_col),
                   eof:  last_rd};
      end
    end
  end

  assign fifo_din = '{pxl: bus.buf_data, tag: tag_q};

  px_fifo2 #(
    .W ($bits(px_word_t))
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.buf_rd_en  = rd_en;
  assign bus.buf_addr   = rd_addr;
  assign bus.proc_valid = !fifo_empty;
  assign bus.proc_pxl   = fifo_dout.pxl;
  assign bus.proc_addr  = fifo_dout.tag.addr;
  assign bus.proc_col   = fifo_dout.tag.col;
  assign bus.proc_row   = fifo_dout.tag.row;
  assign bus.proc_eol   = fifo_dout.tag.eol;
  assign bus.proc_eof   = fifo_dout.tag.eof;

endmodule

// File: tb/tb_px_frame_reader.sv
// Directed bench for px_frame_reader: buffer model mem[a] = a[11:0], raster
// order/tag checks under several back-pressure patterns, overrun and reset.
module tb_px_frame_reader;
  import px_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic frame_rdy;
  logic busy;
  logic overrun;
  int   n_checks = 0;
  int   n_fail   = 0;

  px_frame_reader_if bus();

  px_frame_reader dut (
    .clk       (clk),
    .rst       (rst),
    .frame_rdy (frame_rdy),
    .busy      (busy),
    .overrun   (overrun),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Frame buffer model: one-cycle read latency
  always @(posedge clk) begin
    if (bus.buf_rd_en) bus.buf_data <= 12'(bus.buf_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_valid"},   64'(bus.proc_valid), 64'(0));
    check({pfx, "_busy"},    64'(busy),           64'(0));
    check({pfx, "_overrun"}, 64'(overrun),        64'(0));
    check({pfx, "_rd_en"},   64'(bus.buf_rd_en),  64'(0));
    check({pfx, "_buf_addr"},64'(bus.buf_addr),   64'(0));
    check({pfx, "_addr"},    64'(bus.proc_addr),  64'(0));
    check({pfx, "_pxl"},     64'(bus.proc_pxl),   64'(0));
    check({pfx, "_col"},     64'(bus.proc_col),   64'(0));
    check({pfx, "_row"},     64'(bus.proc_row),   64'(0));
    check({pfx, "_eol"},     64'(bus.proc_eol),   64'(0));
    check({pfx, "_eof"},     64'(bus.proc_eof),   64'(0));
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_rdy = 1'b1;
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low for the first 100 cycles
  task automatic run_stream(input int rmode, input int pulse_at, input int reset_at);
    int          idx      = 0;
    int          cyc      = 0;
    int          issued   = 0;
    int          accepted = 0;
    bit          hold_prev = 1'b0;
    bit          done      = 1'b0;
    logic [39:0] cur_vec;
    logic [39:0] prev_vec  = '0;
    while (!done && idx < int'(c_img_pxls) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      frame_rdy = 1'b0;
      case (rmode)
        0:       bus.proc_ready = 1'b1;
        1:       bus.proc_ready = ($urandom_range(0, 1) == 1);
        default: bus.proc_ready = (cyc > 100);
      endcase
      #1;
      cur_vec = {bus.proc_pxl, bus.proc_addr, bus.proc_col, bus.proc_row,
                 bus.proc_eol, bus.proc_eof};
      if (hold_prev) check("hold_stable", 64'(cur_vec), 64'(prev_vec));
      if (bus.buf_rd_en) issued++;
      if (rmode == 2 && cyc == 100) check("stall_reads", 64'(issued), 64'(2));
      if (bus.proc_valid && bus.proc_ready) begin
        if (idx == reset_at) begin
          rst = 1'b0;
          #1;
          check_zero_outputs("async_rst");
          done = 1'b1;
        end else begin
          accepted++;
          check("addr", 64'(bus.proc_addr), 64'(idx));
          check("pxl",  64'(bus.proc_pxl),  64'(idx % 4096));
          check("col",  64'(bus.proc_col),  64'(idx % 80));
          check("row",  64'(bus.proc_row),  64'(idx / 80));
          check("eol",  64'(bus.proc_eol),  64'((idx % 80) == 79));
          check("eof",  64'(bus.proc_eof),  64'(idx == 4799));
          if (idx == 4799) check("busy_last", 64'(busy), 64'(1));
          if (idx == pulse_at) frame_rdy = 1'b1;
          idx++;
        end
      end
      if (bus.buf_rd_en) check("outstanding", 64'((issued - accepted) <= 2), 64'(1));
      hold_prev = bus.proc_valid && !bus.proc_ready;
      prev_vec  = cur_vec;
    end
    frame_rdy = 1'b0;
    if (!done && idx != int'(c_img_pxls)) check("stream_timeout", 64'(idx), 64'(c_img_pxls));
  endtask

  // Last word was accepted at the previous edge: one DRAIN cycle, then IDLE.
  task automatic end_frame(input bit drain_pulse);
    @(negedge clk);
    #1;
    check("busy_drain", 64'(busy), 64'(1));
    if (drain_pulse) frame_rdy = 1'b1;
    @(negedge clk);
    frame_rdy = 1'b0;
    #1;
    check("busy_idle",  64'(busy),           64'(0));
    check("valid_idle", 64'(bus.proc_valid), 64'(0));
    if (drain_pulse) begin
      check("overrun_drain", 64'(overrun), 64'(1));
      repeat (3) @(negedge clk);
      #1;
      check("no_restart", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    frame_rdy      = 1'b0;
    bus.proc_ready = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Frame 1: first-word latency, then full-rate stream
    @(negedge clk);
    frame_rdy = 1'b1;
    @(negedge clk);
    frame_rdy = 1'b0;
    #1;
    check("lat_gap_rd_en", 64'(bus.buf_rd_en),  64'(0));
    check("lat_n1_valid",  64'(bus.proc_valid), 64'(0));
    check("lat_busy",      64'(busy),           64'(1));
    @(negedge clk);
    #1;
    check("lat_rd_en",     64'(bus.buf_rd_en),  64'(1));
    check("lat_rd_addr",   64'(bus.buf_addr),   64'(0));
    @(negedge clk);
    #1;
    check("lat_n2_valid",  64'(bus.proc_valid), 64'(0));
    @(negedge clk);
    #1;
    check("lat_n3_valid",  64'(bus.proc_valid), 64'(1));
    check("lat_n3_addr",   64'(bus.proc_addr),  64'(0));
    run_stream(0, -1, -1);
    end_frame(1'b0);

    // Frame 2: random back-pressure
    start_frame();
    run_stream(1, -1, -1);
    end_frame(1'b0);

    // Frame 3: consumer stalled at frame start
    bus.proc_ready = 1'b0;
    start_frame();
    run_stream(2, -1, -1);
    end_frame(1'b0);
    check("overrun_clear", 64'(overrun), 64'(0));

    // Frame 4: frame_rdy mid-frame
    start_frame();
    run_stream(0, 1000, -1);
    end_frame(1'b0);
    check("overrun_mid", 64'(overrun), 64'(1));
    repeat (5) @(negedge clk);
    #1;
    check("mid_no_restart", 64'(busy), 64'(0));

    // Frame 5: async reset mid-frame, then a clean restart from address 0
    start_frame();
    run_stream(0, -1, 2000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_frame();
    run_stream(0, -1, -1);
    end_frame(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/px_frame_reader.md
Name: px_frame_reader

Overview:
- Reads one stored frame from the 80x60 pixel frame buffer and replays it as a raster-ordered pixel stream: pixel, address, column and row, with a valid/ready handshake.
- This is the read side of the frame buffer. It produces the processed-pixel/address stream consumed by the column-histogram / LED position logic.
- It starts when the capture side signals that a frame is complete. It tolerates downstream back-pressure and the buffer's 1-cycle read latency.

Parameters:
- c_img_cols, 80, pixels per row
- c_img_rows, 60, rows per frame
- c_img_pxls, c_img_cols*c_img_rows, pixels per frame (4800)
- c_nb_img_pxls, 13, address width
- c_nb_cols, 7, column counter width
- c_nb_rows, 6, row counter width
- c_nb_buf, 12, pixel word width (4R/4G/4B, red in MSBs)

Ports:
- clk  in  1  FPGA clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- frame_rdy  in  1  1-cycle pulse: capture finished writing the buffer
- buf_rd_en  out  1  buffer read strobe
- buf_addr  out  c_nb_img_pxls  buffer read address
- buf_data  in  c_nb_buf  read data, valid exactly 1 cycle after buf_rd_en
- proc_valid  out  1  output word valid
- proc_ready  in  1  downstream accepts the word when proc_valid && proc_ready
- proc_pxl  out  c_nb_buf  pixel value
- proc_addr  out  c_nb_img_pxls  pixel address 0..4799
- proc_col  out  c_nb_cols  column 0..79
- proc_row  out  c_nb_rows  row 0..59
- proc_eol  out  1  high with the last pixel of each row (col==79)
- proc_eof  out  1  high with pixel 4799 only
- busy  out  1  high from frame start until the last pixel is accepted
- overrun  out  1  sticky; set when frame_rdy arrives while busy

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; counters, FIFO and in-flight flag cleared. Any frame in progress is abandoned, with no partial resume.
- FSM states:
  - IDLE: frame_rdy=1 -> READ; read address counter := 0.
  - READ: issue reads 0..c_img_pxls-1. After issuing address 4799 -> DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight -> IDLE.
- busy = (state != IDLE).
- Read issue rule:
  - buf_rd_en=1 in READ only when (fifo_count + inflight - pop) < 2, where pop = proc_valid && proc_ready in the same cycle.
  - buf_addr increments by 1 per issued read and never wraps mid-frame.
- Capture: the cycle after buf_rd_en, buf_data is pushed into a 2-entry output FIFO together with its address, column, row, eol and eof.
  - Column/row counters advance per issued read: col wraps 79->0 and row increments; row stops at 59.
- Output:
  - proc_* reflect the FIFO head; proc_valid = FIFO not empty.
  - While proc_valid && !proc_ready, all proc_* outputs hold stable. Data is never dropped or duplicated.
- Latency: frame_rdy sampled high in IDLE at edge N -> buf_rd_en addr 0 during cycle N+1 -> proc_valid with addr 0 after edge N+3.
- Throughput: 1 pixel/clk when proc_ready is held high; the whole frame takes 4800 cycles plus 3.
- Simultaneous FIFO push and pop: count unchanged, order preserved.
- frame_rdy while busy: ignored for streaming; sets overrun (sticky until reset).
- frame_rdy in the same cycle the FSM returns DRAIN->IDLE: ignored and flagged as overrun. A new frame starts only from IDLE.

Decomposition:
- Shared package (px_pkg): image geometry constants (cols, rows, pxls, widths) and pixel field MSB positions. These are the same constants the histogram block uses.
- One sub-module: px_fifo2, a 2-entry synchronous FIFO (parameterised width; push/pop/count/empty/full), reused for the output buffer.

Test Plan:
- Reset then frame_rdy pulse, proc_ready=1, buffer preloaded mem[a]=a[11:0] -> 4800 words, proc_addr 0..4799 consecutive, proc_pxl==addr[11:0], first valid at N+3, busy falls after addr 4799 is accepted.
- Row/column tagging:
  - addr 79: col=79, row=0, eol=1.
  - addr 80: col=0, row=1, eol=0.
  - addr 4799: col=79, row=59, eol=1, eof=1.
  - eof=0 everywhere else.
- Random proc_ready (50%) -> identical ordered sequence as the no-stall run, proc_* stable while stalled, no more than 2 reads outstanding beyond accepted words.
- frame_rdy pulsed at addr 1000 mid-frame -> overrun=1, stream continues uninterrupted to 4799; no restart.
- rst asserted low at addr 2000 -> all outputs 0 immediately (async). After release and frame_rdy, the stream restarts from addr 0.
- proc_ready held low for 100 cycles at frame start -> exactly 2 reads issued (addr 0,1). On release, the stream resumes in order.
